tap_delay_line: RTL and testbench

- Parametrised tapped delay line for FIR-style datapaths.
- Stores the last DEPTH samples written with `shift`.
- Returns any tap by address through a registered read port, with a fill counter, a full flag, a synchronous clear and an address-range error flag.
- Sits between the sample source and the MAC/coefficient sequencer; it is the generalised successor to the fixed 64-tap shift register.

---
 rtl/tap_delay_line_if.sv | 48 ++++
 rtl/tap_delay_line.sv | 136 +++++++++++++
 tb/tb_tap_delay_line.sv | 333 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/tap_delay_line_if.sv
`default_nettype none
// ============================================================================
// Module      : tap_delay_line_if
// Description : Sample/read bundle between a sample source or MAC sequencer
//               (master) and the tapped delay line (slave). The second read
//               port signals exist only with TAP_DELAY_LINE_DUAL_READ_EN.
// Revision    : 1.0 - initial release
// ============================================================================
interface tap_delay_line_if #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 6
);
  logic                  shift;
  logic                  clear;
  logic [DATA_WIDTH-1:0] din;
  logic [ADDR_WIDTH-1:0] address;
  logic [DATA_WIDTH-1:0] dout;
  logic                  dout_valid;
  logic                  addr_err;
  logic [ADDR_WIDTH:0]   fill;
  logic                  full;
`ifdef TAP_DELAY_LINE_DUAL_READ_EN
  logic [ADDR_WIDTH-1:0] address_b;
  logic [DATA_WIDTH-1:0] dout_b;
  logic                  dout_b_valid;

  modport master (
    output shift, clear, din, address, address_b,
    input  dout, dout_valid, addr_err, fill, full, dout_b, dout_b_valid
  );

  modport slave (
    input  shift, clear, din, address, address_b,
    output dout, dout_valid, addr_err, fill, full, dout_b, dout_b_valid
  );
`else
  modport master (
    output shift, clear, din, address,
    input  dout, dout_valid, addr_err, fill, full
  );

  modport slave (
    input  shift, clear, din, address,
    output dout, dout_valid, addr_err, fill, full
  );
`endif
endinterface
`default_nettype wire

// File: rtl/tap_delay_line.sv
`default_nettype none
// ============================================================================
// Module      : tap_delay_line
// Description : Tapped delay line holding the last DEPTH pushed samples in a
//               circular buffer. Any tap is read by address through a
//               registered port (1-cycle latency); unwritten taps are masked
//               by the fill count. Optional macro TAP_DELAY_LINE_DUAL_READ_EN
//               adds an independent second read port (address_b/dout_b).
// Revision    : 1.0 - initial release
// ============================================================================
module tap_delay_line #(
  parameter int DATA_WIDTH = 16,
  parameter int DEPTH      = 64,
  parameter int ADDR_WIDTH = 6
) (
  input  logic             clk,
  input  logic             rst,
  tap_delay_line_if.slave  bus
);

  localparam logic [ADDR_WIDTH:0]   c_depth   = (ADDR_WIDTH+1)'(DEPTH);
  localparam logic [ADDR_WIDTH:0]   c_one     = (ADDR_WIDTH+1)'(1);
  localparam logic [ADDR_WIDTH-1:0] c_last_wp = ADDR_WIDTH'(DEPTH-1);

  logic [DATA_WIDTH-1:0] r_mem [0:DEPTH-1];
  logic [ADDR_WIDTH-1:0] r_wp;
  logic [ADDR_WIDTH:0]   r_fill;
  logic                  r_full;
  logic [DATA_WIDTH-1:0] r_dout;
  logic                  r_dout_valid;
  logic                  r_addr_err;

  // Buffer index of tap k: (wp - 1 - k) mod DEPTH. Evaluated on an extra bit
  // so the sum never underflows, then folded once since it stays < 2*DEPTH.
  function automatic logic [ADDR_WIDTH-1:0] f_tap_index(
    input logic [ADDR_WIDTH-1:0] wp,
    input logic [ADDR_WIDTH-1:0] tap
  );
    logic [ADDR_WIDTH:0] v_sum;
    v_sum = {1'b0, wp} + c_depth - {1'b0, tap} - c_one;
    if (v_sum >= c_depth) begin
      v_sum = v_sum - c_depth;
    end
    return v_sum[ADDR_WIDTH-1:0];
  endfunction

  // Port A: range check, fill masking and tap fetch, straight into the register.
  logic                  w_a_in_range;
  logic                  w_a_hit;
  logic [DATA_WIDTH-1:0] w_a_data;

  assign w_a_in_range = ({1'b0, bus.address} < c_depth);
  assign w_a_hit      = ({1'b0, bus.address} < r_fill);
  assign w_a_data     = w_a_hit ? r_mem[f_tap_index(r_wp, bus.address)] : '0;

`ifdef TAP_DELAY_LINE_DUAL_READ_EN
  // Port B: same rules as port A, independent address.
  logic                  w_b_in_range;
  logic                  w_b_hit;
  logic [DATA_WIDTH-1:0] w_b_data;
  logic [DATA_WIDTH-1:0] r_dout_b;
  logic                  r_dout_b_valid;

  assign w_b_in_range = ({1'b0, bus.address_b} < c_depth);
  assign w_b_hit      = ({1'b0, bus.address_b} < r_fill);
  assign w_b_data     = w_b_hit ? r_mem[f_tap_index(r_wp, bus.address_b)] : '0;

  // Second read register; clear does not touch it, like port A.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_dout_b       <= '0;
      r_dout_b_valid <= 1'b0;
    end else begin
      r_dout_b       <= w_b_data;
      r_dout_b_valid <= w_b_hit;
    end
  end

  assign bus.dout_b       = r_dout_b;
  assign bus.dout_b_valid = r_dout_b_valid;

  logic w_range_err;
  assign w_range_err = ~w_a_in_range | ~w_b_in_range;
`else
  logic w_range_err;
  assign w_range_err = ~w_a_in_range;
`endif

  // Read register: samples pre-edge history, so a same-edge shift or clear
  // is not yet visible here.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_dout       <= '0;
      r_dout_valid <= 1'b0;
      r_addr_err   <= 1'b0;
    end else begin
      r_dout       <= w_a_data;
      r_dout_valid <= w_a_hit;
      r_addr_err   <= w_range_err;
    end
  end

  // Write pointer and occupancy; clear beats shift, so a same-edge din is dropped.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wp   <= '0;
      r_fill <= '0;
      r_full <= 1'b0;
    end else if (bus.clear) begin
      r_wp   <= '0;
      r_fill <= '0;
      r_full <= 1'b0;
    end else if (bus.shift) begin
      r_wp <= (r_wp == c_last_wp) ? '0 : r_wp + 1'b1;
      if (r_fill != c_depth) begin
        r_fill <= r_fill + c_one;
      end
      r_full <= (r_fill >= c_depth - c_one);
    end
  end

  // Sample storage; never bulk-cleared, stale words are hidden by fill.
  always_ff @(posedge clk) begin
    if (!rst && !bus.clear && bus.shift) begin
      r_mem[r_wp] <= bus.din;
    end
  end

  assign bus.dout       = r_dout;
  assign bus.dout_valid = r_dout_valid;
  assign bus.addr_err   = r_addr_err;
  assign bus.fill       = r_fill;
  assign bus.full       = r_full;

endmodule
`default_nettype wire

// File: tb/tb_tap_delay_line.sv
`default_nettype none
// ============================================================================
// Module      : tb_tap_delay_line
// Description : Self-checking bench for tap_delay_line. Two instances (DEPTH=5
//               and DEPTH=64) share the sample stream; a queue-based history
//               model (index 0 = newest) supplies every expected value.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_tap_delay_line;

  logic        clk;
  logic        rst;
  logic        shift;
  logic        clear;
  logic [15:0] din;
  logic [2:0]  a5;
  logic [5:0]  a64;
  logic [2:0]  b5;
  logic [5:0]  b64;

  int n_checks = 0;
  int n_fail   = 0;

  // history models, element 0 is tap 0
  logic [15:0] h5[$];
  logic [15:0] h64[$];

  // expected registered outputs after the most recent tick
  logic [15:0] e5_d, e64_d, eb5_d, eb64_d;
  logic        e5_v, e64_v, eb5_v, eb64_v;
  logic        e5_e, e64_e;
  logic [3:0]  e5_fill;
  logic [6:0]  e64_fill;
  logic        e5_full, e64_full;

  tap_delay_line_if #(.DATA_WIDTH(16), .ADDR_WIDTH(3)) if5 ();
  tap_delay_line_if #(.DATA_WIDTH(16), .ADDR_WIDTH(6)) if64 ();

  assign if5.shift    = shift;
  assign if5.clear    = clear;
  assign if5.din      = din;
  assign if5.address  = a5;
  assign if64.shift   = shift;
  assign if64.clear   = clear;
  assign if64.din     = din;
  assign if64.address = a64;
`ifdef TAP_DELAY_LINE_DUAL_READ_EN
  assign if5.address_b  = b5;
  assign if64.address_b = b64;
`endif

  tap_delay_line #(.DATA_WIDTH(16), .DEPTH(5), .ADDR_WIDTH(3)) u_dut5 (
    .clk (clk),
    .rst (rst),
    .bus (if5)
  );

  tap_delay_line #(.DATA_WIDTH(16), .DEPTH(64), .ADDR_WIDTH(6)) u_dut64 (
    .clk (clk),
    .rst (rst),
    .bus (if64)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One clock: expectations from pre-edge history, then history update,
  // then settle 1 time unit past the edge for sampling.
  task automatic tick();
    e5_v  = (int'(a5) < h5.size());
    e5_d  = e5_v ? h5[a5] : 16'h0;
    e5_e  = (int'(a5) >= 5);
    e64_v = (int'(a64) < h64.size());
    e64_d = e64_v ? h64[a64] : 16'h0;
    e64_e = 1'b0;
    eb5_v  = (int'(b5) < h5.size());
    eb5_d  = eb5_v ? h5[b5] : 16'h0;
    eb64_v = (int'(b64) < h64.size());
    eb64_d = eb64_v ? h64[b64] : 16'h0;
`ifdef TAP_DELAY_LINE_DUAL_READ_EN
    e5_e = e5_e | (int'(b5) >= 5);
`endif
    @(posedge clk);
    if (rst) begin
      {e5_d, e5_v, e5_e, e64_d, e64_v, e64_e} = '0;
      {eb5_d, eb5_v, eb64_d, eb64_v} = '0;
    end
    if (rst || clear) begin
      h5.delete();
      h64.delete();
    end else if (shift) begin
      h5.push_front(din);
      h64.push_front(din);
      if (h5.size() > 5) void'(h5.pop_back());
      if (h64.size() > 64) void'(h64.pop_back());
    end
    e5_fill  = 4'(h5.size());
    e5_full  = (h5.size() == 5);
    e64_fill = 7'(h64.size());
    e64_full = (h64.size() == 64);
    #1;
  endtask

  task automatic push(input logic [15:0] v);
    shift = 1'b1;
    din   = v;
    tick();
    shift = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; shift = 1'b0; clear = 1'b0; din = '0;
    a5 = '0; a64 = '0; b5 = '0; b64 = '0;
    tick();
    rst = 1'b0;
    n_checks++;
    if ({if5.dout, if5.dout_valid, if5.addr_err, if5.fill, if5.full} !== 23'd0) begin
      n_fail++;
      $display("FAIL reset_d5: got %h required 0", {if5.dout, if5.dout_valid, if5.addr_err, if5.fill, if5.full});
    end
    n_checks++;
    if ({if64.dout, if64.dout_valid, if64.addr_err, if64.fill, if64.full} !== 26'd0) begin
      n_fail++;
      $display("FAIL reset_d64: got %h required 0", {if64.dout, if64.dout_valid, if64.addr_err, if64.fill, if64.full});
    end
  endtask

  task automatic test_fill();
    a5 = 3'd0; a64 = 6'd0;
    push(16'h0001);
    tick();
    n_checks++;
    if ({if5.dout, if5.dout_valid, if5.fill} !== {16'h0001, 1'b1, 4'd1}) begin
      n_fail++;
      $display("FAIL first_push_d5: got dout=%h v=%b fill=%0d required 0001 1 1", if5.dout, if5.dout_valid, if5.fill);
    end
    n_checks++;
    if ({if64.dout, if64.dout_valid, if64.fill} !== {16'h0001, 1'b1, 7'd1}) begin
      n_fail++;
      $display("FAIL first_push_d64: got dout=%h v=%b fill=%0d required 0001 1 1", if64.dout, if64.dout_valid, if64.fill);
    end
  endtask

  task automatic test_ordering();
    push(16'hFFFF);
    push(16'h00FF);
    a5 = 3'd2; tick();
    n_checks++;
    if (if5.dout !== 16'h0001) begin
      n_fail++;
      $display("FAIL order_tap2: got %h required 0001", if5.dout);
    end
    a5 = 3'd0; tick();
    n_checks++;
    if (if5.dout !== 16'h00FF) begin
      n_fail++;
      $display("FAIL order_tap0: got %h required 00ff", if5.dout);
    end
    a5 = 3'd3; tick();
    n_checks++;
    if ({if5.dout, if5.dout_valid, if5.addr_err} !== 18'd0) begin
      n_fail++;
      $display("FAIL order_unwritten: got dout=%h v=%b err=%b required 0 0 0", if5.dout, if5.dout_valid, if5.addr_err);
    end
  endtask

  task automatic test_wrap();
    rst = 1'b1; tick(); rst = 1'b0;
    for (int i = 1; i <= 7; i++) push(16'(i));
    n_checks++;
    if ({if5.fill, if5.full} !== {4'd5, 1'b1}) begin
      n_fail++;
      $display("FAIL wrap_full_d5: got fill=%0d full=%b required 5 1", if5.fill, if5.full);
    end
    for (int k = 0; k < 5; k++) begin
      a5 = 3'(k);
      tick();
      n_checks++;
      if (if5.dout !== 16'(7 - k)) begin
        n_fail++;
        $display("FAIL wrap_tap%0d_d5: got %h required %h", k, if5.dout, 16'(7 - k));
      end
    end
    for (int i = 8; i <= 70; i++) push(16'(i));
    a64 = 6'd63;
    tick();
    n_checks++;
    if ({if64.dout, if64.dout_valid, if64.fill, if64.full} !== {16'd7, 1'b1, 7'd64, 1'b1}) begin
      n_fail++;
      $display("FAIL wrap_tap63_d64: got dout=%h v=%b fill=%0d full=%b required 0007 1 64 1",
               if64.dout, if64.dout_valid, if64.fill, if64.full);
    end
  endtask

  task automatic test_back_to_back();
    a5 = 3'd0; a64 = 6'd0;
    push(16'hAAAA);
    shift = 1'b1; din = 16'h5555;
    tick();
    shift = 1'b0;
    n_checks++;
    if ({if5.dout, if64.dout} !== {16'hAAAA, 16'hAAAA}) begin
      n_fail++;
      $display("FAIL same_edge_read: got %h %h required aaaa aaaa", if5.dout, if64.dout);
    end
    tick();
    n_checks++;
    if ({if5.dout, if64.dout} !== {16'h5555, 16'h5555}) begin
      n_fail++;
      $display("FAIL next_cycle_read: got %h %h required 5555 5555", if5.dout, if64.dout);
    end
  endtask

  task automatic test_clear_shift();
    clear = 1'b1; shift = 1'b1; din = 16'hBEEF;
    tick();
    clear = 1'b0; shift = 1'b0;
    n_checks++;
    if ({if5.fill, if5.full, if64.fill, if64.full} !== 13'd0) begin
      n_fail++;
      $display("FAIL clear_fill: got %0d %b %0d %b required 0 0 0 0", if5.fill, if5.full, if64.fill, if64.full);
    end
    a5 = 3'd0; a64 = 6'd0;
    tick();
    n_checks++;
    if ({if5.dout, if5.dout_valid, if64.dout, if64.dout_valid} !== 34'd0) begin
      n_fail++;
      $display("FAIL clear_masked: got %h %b %h %b required 0 0 0 0", if5.dout, if5.dout_valid, if64.dout, if64.dout_valid);
    end
    push(16'h1234);
    tick();
    n_checks++;
    if ({if5.dout, if5.dout_valid, if64.dout, if64.dout_valid} !== {16'h1234, 1'b1, 16'h1234, 1'b1}) begin
      n_fail++;
      $display("FAIL clear_repush: got %h %b %h %b required 1234 1 1234 1", if5.dout, if5.dout_valid, if64.dout, if64.dout_valid);
    end
  endtask

  task automatic test_range();
    rst = 1'b1; tick(); rst = 1'b0;
    for (int i = 1; i <= 5; i++) push(16'(i * 16'h0010));
    a5 = 3'd6; b5 = 3'd0;
    tick();
    n_checks++;
    if ({if5.dout, if5.dout_valid, if5.addr_err} !== {16'h0, 1'b0, 1'b1}) begin
      n_fail++;
      $display("FAIL range_err: got dout=%h v=%b err=%b required 0 0 1", if5.dout, if5.dout_valid, if5.addr_err);
    end
    a5 = 3'd4;
    tick();
    n_checks++;
    if ({if5.dout, if5.dout_valid, if5.addr_err} !== {16'h0010, 1'b1, 1'b0}) begin
      n_fail++;
      $display("FAIL range_last_tap: got dout=%h v=%b err=%b required 0010 1 0", if5.dout, if5.dout_valid, if5.addr_err);
    end
`ifdef TAP_DELAY_LINE_DUAL_READ_EN
    a5 = 3'd0; b5 = 3'd4;
    tick();
    n_checks++;
    if ({if5.dout, if5.dout_b, if5.dout_b_valid, if5.addr_err} !== {16'h0050, 16'h0010, 1'b1, 1'b0}) begin
      n_fail++;
      $display("FAIL dual_pair: got a=%h b=%h bv=%b err=%b required 0050 0010 1 0",
               if5.dout, if5.dout_b, if5.dout_b_valid, if5.addr_err);
    end
    b5 = 3'd7;
    tick();
    n_checks++;
    if ({if5.dout, if5.dout_valid, if5.dout_b_valid, if5.addr_err} !== {16'h0050, 1'b1, 1'b0, 1'b1}) begin
      n_fail++;
      $display("FAIL dual_err_or: got a=%h av=%b bv=%b err=%b required 0050 1 0 1",
               if5.dout, if5.dout_valid, if5.dout_b_valid, if5.addr_err);
    end
    b5 = 3'd0;
`endif
  endtask

  task automatic test_random();
    rst = 1'b1; tick(); rst = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      rst   = ($urandom_range(0, 199) == 0);
      clear = ($urandom_range(0, 99) < 3);
      shift = ($urandom_range(0, 99) < 65);
      din   = 16'($urandom);
      a5    = 3'($urandom_range(0, 7));
      a64   = 6'($urandom);
      b5    = 3'($urandom_range(0, 7));
      b64   = 6'($urandom);
      tick();
      n_checks++;
      if ({if5.dout, if5.dout_valid, if5.addr_err, if5.fill, if5.full} !==
          {e5_d, e5_v, e5_e, e5_fill, e5_full}) begin
        n_fail++;
        $display("FAIL rand_d5 cyc %0d: got d=%h v=%b e=%b f=%0d full=%b required d=%h v=%b e=%b f=%0d full=%b",
                 i, if5.dout, if5.dout_valid, if5.addr_err, if5.fill, if5.full,
                 e5_d, e5_v, e5_e, e5_fill, e5_full);
      end
      n_checks++;
      if ({if64.dout, if64.dout_valid, if64.addr_err, if64.fill, if64.full} !==
          {e64_d, e64_v, e64_e, e64_fill, e64_full}) begin
        n_fail++;
        $display("FAIL rand_d64 cyc %0d: got d=%h v=%b e=%b f=%0d full=%b required d=%h v=%b e=%b f=%0d full=%b",
                 i, if64.dout, if64.dout_valid, if64.addr_err, if64.fill, if64.full,
                 e64_d, e64_v, e64_e, e64_fill, e64_full);
      end
`ifdef TAP_DELAY_LINE_DUAL_READ_EN
      n_checks++;
      if ({if5.dout_b, if5.dout_b_valid, if64.dout_b, if64.dout_b_valid} !==
          {eb5_d, eb5_v, eb64_d, eb64_v}) begin
        n_fail++;
        $display("FAIL rand_portb cyc %0d: got %h %b %h %b required %h %b %h %b",
                 i, if5.dout_b, if5.dout_b_valid, if64.dout_b, if64.dout_b_valid,
                 eb5_d, eb5_v, eb64_d, eb64_v);
      end
`endif
    end
    rst = 1'b0; clear = 1'b0; shift = 1'b0;
  endtask

  initial begin
    test_reset();
    test_fill();
    test_ordering();
    test_wrap();
    test_back_to_back();
    test_clear_shift();
    test_range();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
